// File: rtl/if_stage.sv
// Instruction fetch stage: drives the imem request, captures fetched words,
// and parks one word in a hold buffer while downstream is stalled.
module if_stage #(
    parameter int              PC_W     = 12,
    parameter int              INST_W   = 19,
    parameter logic [PC_W-1:0] RESET_PC = 12'h000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [PC_W-1:0]   branch_target,
    input  logic              jump,
    input  logic [PC_W-1:0]   jump_target,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic [INST_W-1:0] imem_data,
    output logic [INST_W-1:0] instruction,
    output logic [PC_W-1:0]   pc_plus1,
    output logic              valid,
    output logic              flush
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] ONE = {{(PC_W-1){1'b0}}, 1'b1};

    state_t              state;
    state_t              state_next;
    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     pc_inc;
    logic [PC_W-1:0]     hold_pc;
    logic [PC_W-1:0]     hold_inc;
    logic [INST_W-1:0]   hold_inst;
    logic                redirect;
    logic [PC_W-1:0]     target;

    // Jump wins over a simultaneous taken branch.
    assign redirect  = jump | branch_taken;
    assign target    = jump ? jump_target : branch_target;
    assign pc_inc    = pc + ONE;
    assign hold_inc  = hold_pc + ONE;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        unique case (state)
            BOOT: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (!redirect && imem_ready && stall) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (redirect || !stall) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc          <= RESET_PC;
            instruction <= '0;
            pc_plus1    <= '0;
            valid       <= 1'b0;
            flush       <= 1'b0;
            hold_inst   <= '0;
            hold_pc     <= '0;
        end else begin
            flush <= 1'b0;
            unique case (state)
                FETCH: begin
                    if (redirect) begin
                        pc    <= target;
                        flush <= 1'b1;
                        valid <= 1'b0;
                    end else if (imem_ready) begin
                        if (stall) begin
                            hold_inst <= imem_data;
                            hold_pc   <= pc;
                        end else begin
                            instruction <= imem_data;
                            pc_plus1    <= pc_inc;
                            valid       <= 1'b1;
                            pc          <= pc_inc;
                        end
                    end else if (!stall) begin
                        valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc        <= target;
                        flush     <= 1'b1;
                        valid     <= 1'b0;
                        hold_inst <= '0;
                        hold_pc   <= '0;
                    end else if (!stall) begin
                        instruction <= hold_inst;
                        pc_plus1    <= hold_inc;
                        valid       <= 1'b1;
                        pc          <= hold_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [11:0] branch_target;
    logic        jump;
    logic [11:0] jump_target;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ready;
    logic [18:0] imem_data;
    logic [18:0] instruction;
    logic [11:0] pc_plus1;
    logic        valid;
    logic        flush;
    logic [18:0] salt;

    int n_checks = 0;
    int n_fail   = 0;
    bit armed    = 1'b0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_data    (imem_data),
        .instruction  (instruction),
        .pc_plus1     (pc_plus1),
        .valid        (valid),
        .flush        (flush)
    );

    function automatic logic [18:0] word(input logic [11:0] a);
        return {a[6:0] ^ 7'h2a, a};
    endfunction

    assign imem_data = word(imem_addr) ^ salt;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: fetch pointer, one-word park slot, boot bubble.
    logic [11:0] m_pc, m_pp, m_hp;
    logic [18:0] m_inst, m_hw;
    logic        m_valid, m_flush, m_boot, m_parked;

    always @(posedge clk) begin
        if (!reset) begin
            m_pc = 12'h000; m_boot = 1; m_parked = 0;
            m_inst = 0; m_pp = 0; m_valid = 0; m_flush = 0;
            m_hw = 0; m_hp = 0;
        end else begin
            m_flush = 0;
            if (m_boot) begin
                m_boot = 0;
            end else if (jump || branch_taken) begin
                m_pc = jump ? jump_target : branch_target;
                m_flush = 1; m_valid = 0; m_parked = 0;
            end else if (m_parked) begin
                if (!stall) begin
                    m_inst = m_hw; m_pp = m_hp + 12'd1;
                    m_pc = m_pp; m_valid = 1; m_parked = 0;
                end
            end else if (imem_ready) begin
                if (stall) begin
                    m_hw = imem_data; m_hp = m_pc; m_parked = 1;
                end else begin
                    m_inst = imem_data; m_pp = m_pc + 12'd1;
                    m_pc = m_pp; m_valid = 1;
                end
            end else if (!stall) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("mdl_req", imem_req, !m_boot && !m_parked);
            check("mdl_addr", imem_addr, m_pc);
            check("mdl_valid", valid, m_valid);
            check("mdl_flush", flush, m_flush);
            check("mdl_pp", pc_plus1, m_pp);
            check("mdl_inst", instruction, m_inst);
        end
    end

    task automatic drive(input logic st, input logic rdy, input logic br,
                         input logic [11:0] bt, input logic jp,
                         input logic [11:0] jt);
        stall = st; imem_ready = rdy; branch_taken = br;
        branch_target = bt; jump = jp; jump_target = jt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        salt = '0;
        reset = 1'b0;
        drive(0, 1, 0, 0, 0, 0);
        step();
        armed = 1'b1;
        step();
        check("rst_valid", valid, 0);
        check("rst_inst", instruction, 0);
        check("rst_pp", pc_plus1, 0);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);

        reset = 1'b1;
        step();
        check("boot_req", imem_req, 1);
        check("boot_addr", imem_addr, 0);
        check("boot_valid", valid, 0);
        step();
        check("seq_addr1", imem_addr, 1);
        check("seq_pp1", pc_plus1, 1);
        check("seq_valid", valid, 1);
        check("seq_inst0", instruction, word(12'd0));
        step();
        check("seq_pp2", pc_plus1, 2);
        step();
        check("seq_pp3", pc_plus1, 3);
        check("seq_addr3", imem_addr, 3);
        step();
        step();
        check("at5", imem_addr, 5);

        drive(1, 1, 0, 0, 0, 0);
        step(); step(); step();
        check("hold_req", imem_req, 0);
        check("hold_addr", imem_addr, 5);
        check("hold_pp", pc_plus1, 5);
        drive(0, 1, 0, 0, 0, 0);
        step();
        check("unhold_inst", instruction, word(12'd5));
        check("unhold_pp", pc_plus1, 6);
        check("unhold_addr", imem_addr, 6);

        step();
        drive(0, 0, 0, 0, 0, 0);
        step(); step();
        check("bub_valid", valid, 0);
        check("bub_addr", imem_addr, 7);
        drive(0, 1, 0, 0, 0, 0);
        step();
        check("bub_inst", instruction, word(12'd7));
        check("bub_pp", pc_plus1, 8);

        step(); step();
        check("at10", imem_addr, 10);
        drive(0, 1, 1, 12'd40, 0, 0);
        step();
        check("br_flush", flush, 1);
        check("br_valid", valid, 0);
        check("br_addr", imem_addr, 40);
        drive(0, 1, 1, 12'd40, 1, 12'd80);
        step();
        check("jmp_flush", flush, 1);
        check("jmp_addr", imem_addr, 80);
        drive(0, 1, 0, 0, 0, 0);
        step();
        check("post_flush", flush, 0);
        check("post_inst", instruction, word(12'd80));

        drive(0, 1, 0, 0, 1, 12'hfff);
        step();
        drive(0, 1, 0, 0, 0, 0);
        step();
        check("wrap_pp", pc_plus1, 12'h000);
        check("wrap_addr", imem_addr, 12'h000);

        drive(1, 1, 0, 0, 0, 0);
        step();
        check("hold2_req", imem_req, 0);
        reset = 1'b0;
        drive(1, 1, 1, 12'd99, 0, 0);
        step();
        reset = 1'b1;
        check("rh_valid", valid, 0);
        check("rh_flush", flush, 0);
        check("rh_inst", instruction, 0);
        check("rh_pp", pc_plus1, 0);
        check("rh_addr", imem_addr, 0);
        check("rh_req", imem_req, 0);

        for (int i = 0; i < 3000; i++) begin
            salt = 19'($urandom);
            reset = ($urandom_range(0, 99) != 0);
            stall = ($urandom_range(0, 9) < 3);
            imem_ready = ($urandom_range(0, 9) < 7);
            branch_taken = ($urandom_range(0, 9) == 0);
            jump = ($urandom_range(0, 19) == 0);
            branch_target = 12'($urandom);
            jump_target = 12'($urandom);
            step();
        end

        @(negedge clk);
        armed = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
